// File: rtl/mem_bist_if.sv
// Memory-side port bundle between the BIST sequencer (master) and reg_mem (slave).
// mem_rdata is the memory's registered data_out, valid one cycle after a read address.
interface mem_bist_if #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 6
);
    logic [ADDR_BITS-1:0]  mem_addr;
    logic [DATA_WIDTH-1:0] mem_wdata;
    logic                  mem_wen;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport master (
        output mem_addr,
        output mem_wdata,
        output mem_wen,
        input  mem_rdata
    );

    modport slave (
        input  mem_addr,
        input  mem_wdata,
        input  mem_wen,
        output mem_rdata
    );
endinterface

// File: rtl/mem_bist_ctrl.sv
// Two-pass write/read-verify BIST sequencer for the single-port register memory.
// Pass 0 uses P(a) = SEED + a, pass 1 uses ~P(a); the first mismatch ends the sweep.
module mem_bist_ctrl #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned ADDR_BITS  = 6,
    parameter logic [7:0]  SEED       = 8'hA5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    mem_bist_if.master            mem,
    output logic                  busy,
    output logic                  done,
    output logic                  pass,
    output logic [ADDR_BITS-1:0]  fail_addr,
    output logic [DATA_WIDTH-1:0] fail_data
);

    localparam logic [2:0] StIdle = 3'd0;
    localparam logic [2:0] StW0   = 3'd1;
    localparam logic [2:0] StR0   = 3'd2;
    localparam logic [2:0] StW1   = 3'd3;
    localparam logic [2:0] StR1   = 3'd4;
    localparam logic [2:0] StDone = 3'd5;

    localparam logic [ADDR_BITS-1:0]  LastAddr = {ADDR_BITS{1'b1}};
    localparam logic [DATA_WIDTH-1:0] SeedW    = DATA_WIDTH'(SEED);

    logic [2:0]            state_q, state_d;
    logic [ADDR_BITS-1:0]  addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic                  wen_q, wen_d;
    logic                  drain_q, drain_d;
    logic                  rd_vld_q, rd_vld_d;
    logic [ADDR_BITS-1:0]  rd_addr_q, rd_addr_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  pass_q, pass_d;
    logic [ADDR_BITS-1:0]  fail_addr_q, fail_addr_d;
    logic [DATA_WIDTH-1:0] fail_data_q, fail_data_d;

    logic                  inv_phase;
    logic [DATA_WIDTH-1:0] rd_expect;
    logic                  mismatch;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_BITS-1:0] a,
                                                      input logic inv);
        logic [DATA_WIDTH-1:0] p;
        p = SeedW + DATA_WIDTH'(a);
        return p ^ {DATA_WIDTH{inv}};
    endfunction

    // Pass 1 phases (W1/R1) use the inverted pattern.
    assign inv_phase = (state_q == StW1) || (state_q == StR1);

    // rd_vld_q/rd_addr_q lag the read address by one cycle, matching reg_mem's read latency.
    assign rd_expect = pattern(rd_addr_q, inv_phase);
    assign mismatch  = rd_vld_q && (mem.mem_rdata != rd_expect);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = '0;
        wen_d       = 1'b0;
        drain_d     = drain_q;
        rd_vld_d    = 1'b0;
        rd_addr_d   = rd_addr_q;
        busy_d      = busy_q;
        done_d      = 1'b0;
        pass_d      = pass_q;
        fail_addr_d = fail_addr_q;
        fail_data_d = fail_data_q;

        case (state_q)
            StIdle: begin
                addr_d  = '0;
                drain_d = 1'b0;
                busy_d  = 1'b0;
                if (start) begin
                    state_d     = StW0;
                    busy_d      = 1'b1;
                    pass_d      = 1'b0;
                    fail_addr_d = '0;
                    fail_data_d = '0;
                    wen_d       = 1'b1;
                    wdata_d     = pattern('0, 1'b0);
                end
            end

            StW0, StW1: begin
                if (addr_q == LastAddr) begin
                    addr_d  = '0;
                    drain_d = 1'b0;
                    state_d = (state_q == StW0) ? StR0 : StR1;
                end else begin
                    addr_d  = addr_q + 1'b1;
                    wen_d   = 1'b1;
                    wdata_d = pattern(addr_d, inv_phase);
                end
            end

            StR0, StR1: begin
                if (mismatch) begin
                    fail_addr_d = rd_addr_q;
                    fail_data_d = mem.mem_rdata;
                    pass_d      = 1'b0;
                    busy_d      = 1'b0;
                    done_d      = 1'b1;
                    addr_d      = '0;
                    drain_d     = 1'b0;
                    state_d     = StDone;
                end else if (drain_q) begin
                    // Drain cycle: last read data is compared here, no new read issued.
                    drain_d = 1'b0;
                    addr_d  = '0;
                    if (state_q == StR0) begin
                        state_d = StW1;
                        wen_d   = 1'b1;
                        wdata_d = pattern('0, 1'b1);
                    end else begin
                        state_d = StDone;
                        busy_d  = 1'b0;
                        done_d  = 1'b1;
                        pass_d  = 1'b1;
                    end
                end else begin
                    rd_vld_d  = 1'b1;
                    rd_addr_d = addr_q;
                    if (addr_q == LastAddr) begin
                        drain_d = 1'b1;
                    end else begin
                        addr_d = addr_q + 1'b1;
                    end
                end
            end

            StDone: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                addr_d  = '0;
            end

            default: begin
                state_d = StIdle;
                busy_d  = 1'b0;
                addr_d  = '0;
                drain_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            wdata_q     <= '0;
            wen_q       <= 1'b0;
            drain_q     <= 1'b0;
            rd_vld_q    <= 1'b0;
            rd_addr_q   <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_data_q <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            wen_q       <= wen_d;
            drain_q     <= drain_d;
            rd_vld_q    <= rd_vld_d;
            rd_addr_q   <= rd_addr_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            pass_q      <= pass_d;
            fail_addr_q <= fail_addr_d;
            fail_data_q <= fail_data_d;
        end
    end

    assign mem.mem_addr  = addr_q;
    assign mem.mem_wdata = wdata_q;
    assign mem.mem_wen   = wen_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass          = pass_q;
    assign fail_addr     = fail_addr_q;
    assign fail_data     = fail_data_q;

endmodule
